// File: rtl/iir_output_conditioner_if.sv
// Sample, handshake and status bundle between the IIR filter, the output
// conditioner and the downstream consumer.
interface iir_output_conditioner_if #(
    parameter int word_size_in  = 18,
    parameter int word_size_out = 8
);
    logic [word_size_in-1:0]  Data_in;
    logic                     sample_en;
    logic                     flag_clear;
    logic [word_size_out-1:0] Data_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sat_flag;
    logic                     overrun_flag;

    modport master (
        output Data_in, sample_en, flag_clear, out_ready,
        input  Data_out, out_valid, sat_flag, overrun_flag
    );

    modport slave (
        input  Data_in, sample_en, flag_clear, out_ready,
        output Data_out, out_valid, sat_flag, overrun_flag
    );
endinterface

// File: rtl/iir_output_conditioner.sv
// Decimates, rounds, shifts and saturates IIR filter samples, then buffers
// them in a small FIFO behind a valid/ready handshake with sticky status flags.
module iir_output_conditioner #(
    parameter int word_size_in  = 18,
    parameter int word_size_out = 8,
    parameter int shift         = 10,
    parameter int decim         = 4,
    parameter int fifo_depth    = 4
) (
    input logic                 clock,
    input logic                 reset,
    iir_output_conditioner_if.slave bus
);
    localparam int dcnt_w = (decim > 1) ? $clog2(decim) : 1;
    localparam int ptr_w  = $clog2(fifo_depth);
    localparam int rw     = word_size_in + 1;
    localparam logic [rw-1:0] round_c = rw'(1) << (shift - 1);
    localparam logic [rw-1:0] sat_max = rw'((1 << word_size_out) - 1);

    logic [dcnt_w-1:0]        dcnt;
    logic                     accept;
    logic                     s1_valid;
    logic [rw-1:0]            s1_r;
    logic [rw-1:0]            q;
    logic                     sat;
    logic [word_size_out-1:0] word;

    logic [word_size_out-1:0] mem [fifo_depth];
    logic [ptr_w-1:0]         wr_ptr, rd_ptr;
    logic [ptr_w:0]           count;
    logic                     full, valid, pop, push, drop;
    logic                     sat_q, overrun_q;

    assign accept = bus.sample_en && (dcnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (bus.sample_en) begin
            if (dcnt == dcnt_w'(decim - 1)) dcnt <= '0;
            else                            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_r <= rw'(bus.Data_in) + round_c;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        q    = s1_r >> shift;
        sat  = 1'b0;
        word = q[word_size_out-1:0];
        if (q > sat_max) begin
            sat  = 1'b1;
            word = '1;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign full  = (count == (ptr_w + 1)'(fifo_depth));
    assign valid = (count != '0);
    assign pop   = valid && bus.out_ready;
    assign push  = s1_valid && (!full || pop);
    assign drop  = s1_valid && full && !pop;

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by the reset pointers/count, so stale contents are never observable.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new event on the same edge as flag_clear keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (s1_valid && sat)     sat_q <= 1'b1;
            else if (bus.flag_clear) sat_q <= 1'b0;
            if (drop)                overrun_q <= 1'b1;
            else if (bus.flag_clear) overrun_q <= 1'b0;
        end
    end

    assign bus.out_valid    = valid;
    assign bus.Data_out     = valid ? mem[rd_ptr] : '0;
    assign bus.sat_flag     = sat_q;
    assign bus.overrun_flag = overrun_q;
endmodule

// File: doc/iir_output_conditioner.md
Name: iir_output_conditioner

Overview:
- Downstream stage of the 8th-order IIR filter.
- Takes the filter's unsigned 18-bit Data_out on each sample strobe and decimates by a fixed ratio.
- Rounds and right-shifts each kept sample, then saturates it to an 8-bit word.
- Buffers results in a small FIFO and delivers them to the consumer over a valid/ready handshake, with sticky saturation and overrun flags.

Parameters:
- word_size_in, 18: width of Data_in; equals the filter's Data_out width (2*8+2).
- word_size_out, 8: width of conditioned output.
- shift, 10: right-shift amount applied after rounding; legal range 1..word_size_in-1.
- decim, 4: decimation ratio; 1 keeps every sample; legal range >= 1.
- fifo_depth, 4: output FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- Data_in  input  word_size_in  unsigned filter output sample.
- sample_en  input  1  strobe: Data_in is a new sample this cycle.
- flag_clear  input  1  synchronous clear of sticky flags.
- Data_out  output  word_size_out  FIFO head value; 0 when out_valid=0.
- out_valid  output  1  Data_out holds a valid conditioned sample.
- out_ready  input  1  consumer accepts Data_out this cycle.
- sat_flag  output  1  sticky: at least one sample saturated.
- overrun_flag  output  1  sticky: at least one kept sample dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Clears the decimation counter, pipeline valid bits, FIFO pointers/count and both flags.
  - Outputs during and after reset: out_valid=0, Data_out=0, sat_flag=0, overrun_flag=0.
  - A reset mid-stream discards all in-flight and buffered samples.
- Decimation:
  - Counter dcnt runs 0..decim-1 and advances only on edges with sample_en=1, wrapping decim-1 -> 0.
  - A sample is kept when sample_en=1 and dcnt==0. The first sample after reset is therefore kept, followed by every decim-th strobed sample.
  - sample_en=0 edges are ignored entirely; strobes need not be contiguous.
- Pipeline, stage 1 (register at accept edge E): r = Data_in + 2^(shift-1), width word_size_in+1 so the add cannot overflow.
- Pipeline, stage 2 (edge E+1): q = r >> shift.
  - If q > 2^word_size_out-1, q is replaced by 2^word_size_out-1 and sat_flag is set.
  - The result is then pushed to the FIFO.
- Latency: an accepted sample is at the FIFO head and drives out_valid=1 after edge E+1, i.e. 2 clocks, provided the FIFO was empty.
- Throughput: one kept sample per clock sustained (decim=1, sample_en=1 continuously).
- Handshake:
  - Pop occurs on an edge where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, Data_out and out_valid hold stable.
  - out_valid depends only on FIFO occupancy, never on out_ready.
- FIFO boundaries:
  - Empty: out_valid=0, Data_out=0; a pop attempt has no effect.
  - Full with push and pop on the same edge: both succeed, occupancy stays full, nothing dropped.
  - Full with push and no pop: the new sample is discarded, overrun_flag is set, and existing entries are unchanged.
  - Ordering is strict FIFO; pointers wrap modulo fifo_depth.
- Flags:
  - Sticky until reset or flag_clear.
  - If flag_clear=1 on the same edge a new saturation or overrun event occurs, the event wins and the flag remains 1.
  - flag_clear does not affect data or FIFO state.

Test Plan:
- Reset, then Data_in=18'd5120 with sample_en=1 for 8 clocks, out_ready=1 -> two outputs of 8'd5; first valid 2 clocks after the first accept, second 4 clocks later; sat_flag=0.
- Rounding with decim=1: Data_in 1535 -> 8'd1; 1536 -> 8'd2; 0 -> 8'd0; 261119 -> 8'd255 with sat_flag=0 (exact top); 261632 -> 8'd255 with sat_flag=1.
- Saturation: Data_in=18'h3FFFF -> Data_out=8'd255, sat_flag=1; a following in-range sample leaves the flag at 1; flag_clear pulse -> 0; flag_clear coincident with a saturating sample -> flag stays 1.
- Backpressure: out_ready=0, decim=4, 20 strobed samples 1024*k -> FIFO holds k=0,4,8,12 and the 5th kept sample (k=16) is dropped with overrun_flag=1. Then out_ready=1 drains 0,4,8,12 in order; Data_out is stable throughout the stall.
- Full with simultaneous pop and push: FIFO full, out_ready=1 on the edge a new kept sample arrives -> no drop, overrun_flag stays 0, and the new value appears last.
- Asynchronous reset asserted mid-stream between edges -> out_valid, Data_out and flags go to 0 immediately. After release, the first strobed sample is kept (decimation restarts) and no pre-reset data emerges.
